llc_tracker_regs: RTL and testbench



---
 rtl/llc_tracker_regs_pkg.sv | 25 ++
 rtl/llc_dma_chan.sv | 57 +++++
 rtl/llc_tracker_regs.sv | 203 ++++++++++++++++++++
 tb/tb_llc_tracker_regs.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_tracker_regs_pkg.sv
// Shared LLC constants and types for the tracker register block: set/tag widths,
// line-address and burst-length helpers, DMA/stall defaults and the sweep state type.
package llc_tracker_regs_pkg;

    localparam int LLC_SET_BITS        = 10;
    localparam int LLC_TAG_BITS        = 18;
    localparam int LLC_WAYS            = 16;
    localparam int LLC_LA_BITS         = LLC_TAG_BITS + LLC_SET_BITS;
    localparam int LLC_DMA_CH_DEF      = 2;
    localparam int LLC_LEN_BITS_DEF    = 8;
    localparam int LLC_STALL_DEPTH_DEF = 4;

    typedef logic [LLC_LA_BITS-1:0]      llc_line_addr_t;
    typedef logic [LLC_LEN_BITS_DEF-1:0] llc_len_t;

    typedef enum logic {
        SWEEP_IDLE = 1'b0,
        SWEEP_RUN  = 1'b1
    } sweep_state_e;

    function automatic int llc_line_addr_bits(input int set_bits, input int tag_bits);
        return set_bits + tag_bits;
    endfunction

endpackage

// File: rtl/llc_dma_chan.sv
// One DMA burst channel: line-address counter, remaining-beat counter, active flag
// and the combinational last-beat indicator.
module llc_dma_chan #(
    parameter int LA       = 28,
    parameter int LEN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [LA-1:0]       load_addr,
    input  logic [LEN_BITS-1:0] load_len,
    input  logic                beat,
    output logic [LA-1:0]       addr,
    output logic                active,
    output logic                last
);

    logic [LA-1:0]       addr_q, addr_d;
    logic [LEN_BITS-1:0] rem_q, rem_d;
    logic                active_q, active_d;

    always_comb begin
        addr_d   = addr_q;
        rem_d    = rem_q;
        active_d = active_q;
        if (load) begin
            addr_d   = load_addr;
            // A zero-length burst still moves one beat.
            rem_d    = (load_len == '0) ? LEN_BITS'(1) : load_len;
            active_d = 1'b1;
        end else if (beat && active_q) begin
            addr_d = addr_q + LA'(1);
            rem_d  = rem_q - LEN_BITS'(1);
            if (rem_q == LEN_BITS'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr_q   <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            active_q <= active_d;
        end
    end

    assign addr   = addr_q;
    assign active = active_q;
    assign last   = active_q && (rem_q == LEN_BITS'(1));

endmodule

// File: rtl/llc_tracker_regs.sv
// LLC sequential bookkeeping: set sweep, DMA burst channels, stalled-request FIFO and
// eviction-address capture. Define LLC_STALL_HIT_EN to build the FIFO set-conflict check.
module llc_tracker_regs
    import llc_tracker_regs_pkg::*;
#(
    parameter int SET_BITS    = LLC_SET_BITS,
    parameter int TAG_BITS    = LLC_TAG_BITS,
    parameter int WAYS        = LLC_WAYS,
    parameter int DMA_CH      = LLC_DMA_CH_DEF,
    parameter int LEN_BITS    = LLC_LEN_BITS_DEF,
    parameter int STALL_DEPTH = LLC_STALL_DEPTH_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    rst_state,
    input  logic                                    sweep_start,
    input  logic                                    sweep_incr,
    output logic [SET_BITS-1:0]                     sweep_set,
    output logic                                    sweep_busy,
    output logic                                    sweep_done,
    input  logic [DMA_CH-1:0]                       dma_load,
    input  logic [TAG_BITS+SET_BITS-1:0]            dma_load_addr,
    input  logic [LEN_BITS-1:0]                     dma_load_len,
    input  logic [DMA_CH-1:0]                       dma_beat,
    output logic [DMA_CH*(TAG_BITS+SET_BITS)-1:0]   dma_addr,
    output logic [DMA_CH-1:0]                       dma_active,
    output logic [DMA_CH-1:0]                       dma_last,
    input  logic                                    stall_push,
    input  logic [SET_BITS-1:0]                     stall_push_set,
    input  logic [TAG_BITS-1:0]                     stall_push_tag,
    input  logic                                    stall_pop,
    output logic [SET_BITS-1:0]                     stall_head_set,
    output logic [TAG_BITS-1:0]                     stall_head_tag,
    output logic                                    stall_valid,
    output logic                                    stall_full,
    output logic [$clog2(STALL_DEPTH):0]            stall_count,
    output logic                                    stall_ovf,
    input  logic [SET_BITS-1:0]                     match_set,
    output logic                                    stall_hit,
    input  logic                                    lookup_en,
    input  logic [$clog2(WAYS)-1:0]                 way_next,
    input  logic [SET_BITS-1:0]                     set,
    input  logic [WAYS*TAG_BITS-1:0]                tags_buf,
    output logic [TAG_BITS+SET_BITS-1:0]            addr_evict
);

    localparam int LA       = llc_line_addr_bits(SET_BITS, TAG_BITS);
    localparam int PTR_BITS = $clog2(STALL_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    // ---------------- sweep counter ----------------
    sweep_state_e        sweep_state_q, sweep_state_d;
    logic [SET_BITS-1:0] sweep_set_q, sweep_set_d;
    logic                sweep_done_q, sweep_done_d;

    always_comb begin
        sweep_state_d = sweep_state_q;
        sweep_set_d   = sweep_set_q;
        sweep_done_d  = 1'b0;
        if (sweep_start) begin
            sweep_set_d   = '0;
            sweep_state_d = SWEEP_RUN;
        end else if (sweep_incr && (sweep_state_q == SWEEP_RUN)) begin
            if (sweep_set_q == '1) begin
                sweep_set_d   = '0;
                sweep_state_d = SWEEP_IDLE;
                sweep_done_d  = 1'b1;
            end else begin
                sweep_set_d = sweep_set_q + SET_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rst_state) begin
            sweep_state_q <= SWEEP_IDLE;
            sweep_set_q   <= '0;
            sweep_done_q  <= 1'b0;
        end else begin
            sweep_state_q <= sweep_state_d;
            sweep_set_q   <= sweep_set_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    assign sweep_set  = sweep_set_q;
    assign sweep_busy = (sweep_state_q == SWEEP_RUN);
    assign sweep_done = sweep_done_q;

    // ---------------- DMA channels ----------------
    for (genvar gi = 0; gi < DMA_CH; gi++) begin : g_chan
        llc_dma_chan #(
            .LA       (LA),
            .LEN_BITS (LEN_BITS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .clr       (rst_state),
            .load      (dma_load[gi]),
            .load_addr (dma_load_addr),
            .load_len  (dma_load_len),
            .beat      (dma_beat[gi]),
            .addr      (dma_addr[gi*LA +: LA]),
            .active    (dma_active[gi]),
            .last      (dma_last[gi])
        );
    end

    // ---------------- stall FIFO ----------------
    logic [SET_BITS-1:0] set_mem [STALL_DEPTH];
    logic [TAG_BITS-1:0] tag_mem [STALL_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                full, do_push, do_pop;

    assign full = (count_q == CNT_BITS'(STALL_DEPTH));

    always_comb begin
        do_pop   = stall_pop && (count_q != '0);
        // When full, a push only lands if a pop frees the head in the same cycle.
        do_push  = stall_push && (!full || stall_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q || (stall_push && full && !stall_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || rst_state) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !rst_state) begin
            set_mem[wr_ptr_q] <= stall_push_set;
            tag_mem[wr_ptr_q] <= stall_push_tag;
        end
    end

    // Storage is not cleared; head outputs are masked so an empty FIFO reads as zero.
    assign stall_valid    = (count_q != '0);
    assign stall_full     = full;
    assign stall_count    = count_q;
    assign stall_ovf      = ovf_q;
    assign stall_head_set = stall_valid ? set_mem[rd_ptr_q] : '0;
    assign stall_head_tag = stall_valid ? tag_mem[rd_ptr_q] : '0;

`ifdef LLC_STALL_HIT_EN
    logic [STALL_DEPTH-1:0] hit_vec;
    for (genvar gi = 0; gi < STALL_DEPTH; gi++) begin : g_hit
        logic [PTR_BITS-1:0] offs;
        // Entry gi is live when its distance from the head is below the count.
        assign offs        = PTR_BITS'(gi) - rd_ptr_q;
        assign hit_vec[gi] = ({1'b0, offs} < count_q) && (set_mem[gi] == match_set);
    end
    assign stall_hit = |hit_vec;
`else
    logic unused_match_set;
    assign unused_match_set = ^match_set;
    assign stall_hit        = 1'b0;
`endif

    // ---------------- eviction capture ----------------
    logic [TAG_BITS-1:0] tag_way [WAYS];
    logic [LA-1:0]       evict_q, evict_d;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign tag_way[gi] = tags_buf[gi*TAG_BITS +: TAG_BITS];
    end

    always_comb begin
        evict_d = evict_q;
        if (lookup_en) begin
            evict_d = {tag_way[way_next], set};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evict_q <= '0;
        end else if (!rst_state) begin
            evict_q <= evict_d;
        end
    end

    assign addr_evict = evict_q;

endmodule

// File: tb/tb_llc_tracker_regs.sv
// Self-checking bench for llc_tracker_regs: directed vectors, hand sequences and
// randomized traffic compared every cycle against a queue/array reference model.
module tb_llc_tracker_regs;

    localparam int SET_BITS    = 5;
    localparam int TAG_BITS    = 8;
    localparam int WAYS        = 4;
    localparam int DMA_CH      = 2;
    localparam int LEN_BITS    = 4;
    localparam int STALL_DEPTH = 4;
    localparam int LA          = SET_BITS + TAG_BITS;
    localparam int SETS        = 1 << SET_BITS;
`ifdef LLC_STALL_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic                        clk, rst, rst_state;
    logic                        sweep_start, sweep_incr;
    logic [SET_BITS-1:0]         sweep_set;
    logic                        sweep_busy, sweep_done;
    logic [DMA_CH-1:0]           dma_load, dma_beat, dma_active, dma_last;
    logic [LA-1:0]               dma_load_addr;
    logic [LEN_BITS-1:0]         dma_load_len;
    logic [DMA_CH*LA-1:0]        dma_addr;
    logic                        stall_push, stall_pop;
    logic [SET_BITS-1:0]         stall_push_set, stall_head_set, match_set;
    logic [TAG_BITS-1:0]         stall_push_tag, stall_head_tag;
    logic                        stall_valid, stall_full, stall_ovf, stall_hit;
    logic [2:0]                  stall_count;
    logic                        lookup_en;
    logic [1:0]                  way_next;
    logic [SET_BITS-1:0]         set;
    logic [WAYS*TAG_BITS-1:0]    tags_buf;
    logic [LA-1:0]               addr_evict;

    llc_tracker_regs #(
        .SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS), .WAYS(WAYS),
        .DMA_CH(DMA_CH), .LEN_BITS(LEN_BITS), .STALL_DEPTH(STALL_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rst_state(rst_state),
        .sweep_start(sweep_start), .sweep_incr(sweep_incr),
        .sweep_set(sweep_set), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .dma_load(dma_load), .dma_load_addr(dma_load_addr), .dma_load_len(dma_load_len),
        .dma_beat(dma_beat), .dma_addr(dma_addr), .dma_active(dma_active), .dma_last(dma_last),
        .stall_push(stall_push), .stall_push_set(stall_push_set), .stall_push_tag(stall_push_tag),
        .stall_pop(stall_pop), .stall_head_set(stall_head_set), .stall_head_tag(stall_head_tag),
        .stall_valid(stall_valid), .stall_full(stall_full), .stall_count(stall_count),
        .stall_ovf(stall_ovf), .match_set(match_set), .stall_hit(stall_hit),
        .lookup_en(lookup_en), .way_next(way_next), .set(set), .tags_buf(tags_buf),
        .addr_evict(addr_evict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [SET_BITS-1:0] s;
        logic [TAG_BITS-1:0] t;
    } ent_t;

    ent_t          m_q[$];
    bit            m_ovf;
    int            m_sset;
    bit            m_busy, m_done;
    logic [LA-1:0] m_addr[DMA_CH];
    int            m_rem[DMA_CH];
    bit            m_act[DMA_CH];
    logic [LA-1:0] m_evict;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ovf  = 1'b0;
        m_sset = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
        for (int c = 0; c < DMA_CH; c++) begin
            m_addr[c] = '0;
            m_rem[c]  = 0;
            m_act[c]  = 1'b0;
        end
    endtask

    task automatic model_update();
        bit   was_full;
        ent_t e;
        if (rst) begin
            model_clear();
            m_evict = '0;
        end else if (rst_state) begin
            model_clear();
        end else begin
            m_done = 1'b0;
            if (sweep_start) begin
                m_sset = 0;
                m_busy = 1'b1;
            end else if (sweep_incr && m_busy) begin
                m_sset = m_sset + 1;
                if (m_sset == SETS) begin
                    m_sset = 0;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            for (int c = 0; c < DMA_CH; c++) begin
                if (dma_load[c]) begin
                    m_addr[c] = dma_load_addr;
                    m_rem[c]  = (dma_load_len == 0) ? 1 : int'(dma_load_len);
                    m_act[c]  = 1'b1;
                end else if (dma_beat[c] && m_act[c]) begin
                    m_addr[c] = m_addr[c] + 1'b1;
                    m_rem[c]  = m_rem[c] - 1;
                    m_act[c]  = (m_rem[c] != 0);
                end
            end
            was_full = (m_q.size() == STALL_DEPTH);
            if (stall_pop && m_q.size() > 0) void'(m_q.pop_front());
            if (stall_push) begin
                if (was_full && !stall_pop) begin
                    m_ovf = 1'b1;
                end else begin
                    e.s = stall_push_set;
                    e.t = stall_push_tag;
                    m_q.push_back(e);
                end
            end
            if (lookup_en) m_evict = {tags_buf[way_next*TAG_BITS +: TAG_BITS], set};
        end
    endtask

    task automatic check_all();
        bit exp_hit;
        chk("sweep_set", sweep_set, m_sset);
        chk("sweep_busy", sweep_busy, m_busy);
        chk("sweep_done", sweep_done, m_done);
        for (int c = 0; c < DMA_CH; c++) begin
            chk($sformatf("dma_addr[%0d]", c), dma_addr[c*LA +: LA], m_addr[c]);
            chk($sformatf("dma_active[%0d]", c), dma_active[c], m_act[c]);
            chk($sformatf("dma_last[%0d]", c), dma_last[c], m_act[c] && m_rem[c] == 1);
        end
        chk("stall_count", stall_count, m_q.size());
        chk("stall_valid", stall_valid, m_q.size() > 0);
        chk("stall_full", stall_full, m_q.size() == STALL_DEPTH);
        chk("stall_ovf", stall_ovf, m_ovf);
        if (m_q.size() > 0) begin
            chk("stall_head_set", stall_head_set, m_q[0].s);
            chk("stall_head_tag", stall_head_tag, m_q[0].t);
        end
        exp_hit = 1'b0;
        foreach (m_q[i]) if (m_q[i].s == match_set) exp_hit = HIT_EN;
        chk("stall_hit", stall_hit, exp_hit);
        chk("addr_evict", addr_evict, m_evict);
    endtask

    task automatic clear_strobes();
        rst = 0; rst_state = 0; sweep_start = 0; sweep_incr = 0;
        dma_load = '0; dma_beat = '0; stall_push = 0; stall_pop = 0; lookup_en = 0;
    endtask

    // One clock: model follows the edge, everything checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        @(negedge clk);
        clear_strobes();
    endtask

    // ---------------- directed FIFO vectors ----------------
    typedef struct {
        bit                  push;
        bit                  pop;
        logic [SET_BITS-1:0] pset;
        logic [TAG_BITS-1:0] ptag;
        int                  exp_count;
        bit                  exp_ovf;
        logic [SET_BITS-1:0] exp_head;
    } fvec_t;

    fvec_t fv[8];

    initial begin
        clear_strobes();
        dma_load_addr = '0; dma_load_len = '0;
        stall_push_set = '0; stall_push_tag = '0; match_set = '0;
        way_next = '0; set = '0; tags_buf = '0;
        model_clear();
        m_evict = '0;

        fv[0] = '{1'b1, 1'b0, 5'h01, 8'hA1, 1, 1'b0, 5'h01};
        fv[1] = '{1'b1, 1'b0, 5'h02, 8'hA2, 2, 1'b0, 5'h01};
        fv[2] = '{1'b1, 1'b0, 5'h03, 8'hA3, 3, 1'b0, 5'h01};
        fv[3] = '{1'b1, 1'b0, 5'h04, 8'hA4, 4, 1'b0, 5'h01};
        fv[4] = '{1'b1, 1'b0, 5'h05, 8'hA5, 4, 1'b1, 5'h01};
        fv[5] = '{1'b1, 1'b1, 5'h06, 8'hA6, 4, 1'b1, 5'h02};
        fv[6] = '{1'b0, 1'b1, 5'h00, 8'h00, 3, 1'b1, 5'h03};
        fv[7] = '{1'b1, 1'b1, 5'h07, 8'hA7, 3, 1'b1, 5'h04};

        // Reset state
        @(negedge clk);
        rst = 1;
        tick();
        chk("reset_valid", stall_valid, 1'b0);
        chk("reset_busy", sweep_busy, 1'b0);
        chk("reset_evict", addr_evict, '0);
        $display("reset: count=%0d busy=%0b active=%b", stall_count, sweep_busy, dma_active);

        for (int i = 0; i < 8; i++) begin
            stall_push = fv[i].push; stall_pop = fv[i].pop;
            stall_push_set = fv[i].pset; stall_push_tag = fv[i].ptag;
            tick();
            chk($sformatf("vec%0d_count", i), stall_count, fv[i].exp_count);
            chk($sformatf("vec%0d_ovf", i), stall_ovf, fv[i].exp_ovf);
            chk($sformatf("vec%0d_head", i), stall_head_set, fv[i].exp_head);
            $display("fifo vec %0d: push=%0b pop=%0b count=%0d ovf=%0b head=0x%0h",
                     i, fv[i].push, fv[i].pop, stall_count, stall_ovf, stall_head_set);
        end

        // Sweep across all sets with wrap and done pulse
        rst_state = 1; tick();
        sweep_start = 1; tick();
        chk("sweep_start_set", sweep_set, 0);
        chk("sweep_start_busy", sweep_busy, 1'b1);
        for (int i = 0; i < SETS; i++) begin
            sweep_incr = 1; tick();
            if (i < SETS - 1) begin
                chk("sweep_incr_set", sweep_set, i + 1);
            end else begin
                chk("sweep_wrap_set", sweep_set, 0);
                chk("sweep_wrap_busy", sweep_busy, 1'b0);
                chk("sweep_wrap_done", sweep_done, 1'b1);
            end
        end
        sweep_incr = 1; tick();
        chk("sweep_done_pulse", sweep_done, 1'b0);
        chk("sweep_idle_incr", sweep_set, 0);
        $display("sweep: wrapped, busy=%0b done=%0b", sweep_busy, sweep_done);

        // DMA ch1 all-ones address, length 3
        rst_state = 1; tick();
        dma_load = 2'b10; dma_load_addr = '1; dma_load_len = 4'd3; tick();
        chk("dma1_load_addr", dma_addr[LA +: LA], {LA{1'b1}});
        dma_beat = 2'b10; tick();
        chk("dma1_wrap_addr", dma_addr[LA +: LA], 0);
        dma_beat = 2'b10; tick();
        chk("dma1_last_before_3rd", dma_last[1], 1'b1);
        dma_beat = 2'b10; tick();
        chk("dma1_active_clear", dma_active[1], 1'b0);
        chk("dma1_final_addr", dma_addr[LA +: LA], 2);
        chk("dma0_untouched", dma_active[0], 1'b0);
        chk("dma0_addr_untouched", dma_addr[0 +: LA], 0);
        $display("dma ch1: addr=0x%0h active=%b", dma_addr[LA +: LA], dma_active);

        // Length 0 acts as a single beat
        dma_load = 2'b01; dma_load_addr = 13'h0010; dma_load_len = 4'd0; tick();
        chk("len0_active", dma_active[0], 1'b1);
        chk("len0_last", dma_last[0], 1'b1);
        dma_beat = 2'b01; tick();
        chk("len0_done", dma_active[0], 1'b0);
        dma_beat = 2'b01; tick();
        chk("len0_beat_ignored", dma_addr[0 +: LA], 13'h0011);
        $display("dma len0: addr=0x%0h active=%b", dma_addr[0 +: LA], dma_active);

        // Set-conflict check
        rst_state = 1; tick();
        match_set = 5'h12;
        stall_push = 1; stall_push_set = 5'h12; stall_push_tag = 8'h34; tick();
        chk("hit_after_push", stall_hit, HIT_EN);
        stall_pop = 1; tick();
        chk("hit_after_pop", stall_hit, 1'b0);
        $display("stall hit: enabled=%0b", HIT_EN);

        // Soft clear mid-burst keeps the captured eviction address
        tags_buf = 32'hDD_CC_BB_AA; way_next = 2'd2; set = 5'h07;
        lookup_en = 1; dma_load = 2'b01; dma_load_addr = 13'h0100; dma_load_len = 4'd5;
        stall_push = 1; stall_push_set = 5'h03; stall_push_tag = 8'h55; sweep_start = 1;
        tick();
        dma_beat = 2'b01; tick();
        rst_state = 1; tick();
        chk("rs_active", dma_active, '0);
        chk("rs_addr", dma_addr, '0);
        chk("rs_count", stall_count, 0);
        chk("rs_head_set", stall_head_set, '0);
        chk("rs_busy", sweep_busy, 1'b0);
        chk("rs_evict_kept", addr_evict, {8'hCC, 5'h07});
        $display("rst_state: evict=0x%0h count=%0d", addr_evict, stall_count);

        // Hard reset mid-burst, mid-sweep clears everything
        dma_load = 2'b11; dma_load_len = 4'd4; sweep_start = 1;
        stall_push = 1; tick();
        rst = 1; tick();
        chk("rst_active", dma_active, '0);
        chk("rst_busy", sweep_busy, 1'b0);
        chk("rst_valid", stall_valid, 1'b0);
        chk("rst_evict", addr_evict, '0);
        $display("rst: evict=0x%0h active=%b", addr_evict, dma_active);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 499) == 0);
            rst_state   = ($urandom_range(0, 299) == 0);
            sweep_start = ($urandom_range(0, 63) == 0);
            sweep_incr  = $urandom_range(0, 1);
            dma_load    = DMA_CH'($urandom_range(0, 15) == 0 ? $urandom : 0);
            dma_beat    = DMA_CH'($urandom);
            dma_load_addr = LA'($urandom);
            dma_load_len  = LEN_BITS'($urandom);
            stall_push  = $urandom_range(0, 1);
            stall_pop   = ($urandom_range(0, 2) == 0);
            stall_push_set = SET_BITS'($urandom_range(0, 7));
            stall_push_tag = TAG_BITS'($urandom);
            match_set   = SET_BITS'($urandom_range(0, 7));
            lookup_en   = !rst_state && ($urandom_range(0, 3) == 0);
            way_next    = 2'($urandom);
            set         = SET_BITS'($urandom);
            tags_buf    = $urandom;
            tick();
        end
        $display("random: 4000 cycles applied");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
